// File: rtl/prog_delay_line_if.sv
// Sample/control bundle for the programmable delay line.
// master = sample source / controller, slave = delay line.
interface prog_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int DLY_W = 5
);
    logic             en;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic [DLY_W-1:0] dly;
    logic             dly_load;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [DLY_W-1:0] dly_active;
    logic             dly_err;

    modport master (
        output en, din, din_valid, dly, dly_load,
        input  dout, dout_valid, dly_active, dly_err
    );

    modport slave (
        input  en, din, din_valid, dly, dly_load,
        output dout, dout_valid, dly_active, dly_err
    );
endinterface

// File: rtl/prog_delay_line.sv
// Run-time programmable delay line: 0..MAX_DELAY extra enabled stages
// in front of a registered output. Loading a new delay flushes all
// in-flight valid bits so misaligned samples never reach the DAC.
module prog_delay_line #(
    parameter int WIDTH       = 8,
    parameter int MAX_DELAY   = 16,
    parameter int DLY_W       = 5,
    parameter int DEFAULT_DLY = 0
) (
    input logic              clk,
    input logic              rst,
    prog_delay_line_if.slave bus
);
    localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);
    localparam logic [DLY_W-1:0] DEF_D = DLY_W'(DEFAULT_DLY);

    logic [MAX_DELAY-1:0][WIDTH-1:0] stage_data;
    logic [MAX_DELAY-1:0]            vld_pipe;
    logic [WIDTH-1:0]                tap_data;
    logic                            tap_vld;
    logic [WIDTH-1:0]                dout_q;
    logic                            dout_vld_q;
    logic [DLY_W-1:0]                dly_q;
    logic                            err_q;

    // Stage data shifts on every enabled edge; never reset or flushed,
    // the valid bits alone decide what is presented.
    always_ff @(posedge clk) begin
        if (bus.en) begin
            stage_data[0] <= bus.din;
            for (int k = 1; k < MAX_DELAY; k++)
                stage_data[k] <= stage_data[k-1];
        end
    end

    // Valid pipe: reset/flush clears it; a load coinciding with en still
    // captures the incoming sample so it emerges after the new latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (bus.dly_load) begin
            vld_pipe <= '0;
            if (bus.en)
                vld_pipe[0] <= bus.din_valid;
        end else if (bus.en) begin
            vld_pipe[0] <= bus.din_valid;
            for (int k = 1; k < MAX_DELAY; k++)
                vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    // Tap select: delay 0 bypasses the stages, delay d reads stage d-1.
    always_comb begin
        tap_data = bus.din;
        tap_vld  = bus.din_valid;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (dly_q == DLY_W'(k)) begin
                tap_data = stage_data[k-1];
                tap_vld  = vld_pipe[k-1];
            end
        end
    end

    // Output register; a load only drops the valid, data just holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else if (bus.dly_load) begin
            dout_vld_q <= 1'b0;
        end else if (bus.en) begin
            dout_q     <= tap_data;
            dout_vld_q <= tap_vld;
        end
    end

    // Delay setting with clamping; error flag is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q <= DEF_D;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.dly_load) begin
                if (bus.dly > MAX_D) begin
                    dly_q <= MAX_D;
                    err_q <= 1'b1;
                end else begin
                    dly_q <= bus.dly;
                end
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_vld_q;
    assign bus.dly_active = dly_q;
    assign bus.dly_err    = err_q;
endmodule

// File: tb/tb_prog_delay_line.sv
// Bench for prog_delay_line: directed scenarios plus a random soak,
// all checked against a history-queue model of the delay line.
module tb_prog_delay_line;
    localparam int W    = 8;
    localparam int MAXD = 16;
    localparam int DW   = 5;
    localparam int DEF  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_delay_line_if #(.WIDTH(W), .DLY_W(DW)) bus();

    prog_delay_line #(
        .WIDTH(W), .MAX_DELAY(MAXD), .DLY_W(DW), .DEFAULT_DLY(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: every sample accepted since the last flush, oldest first.
    // After an enabled edge the output is the sample accepted m_dly
    // enabled edges earlier, if one exists since the flush.
    typedef struct {
        logic [W-1:0] d;
        logic         v;
    } smp_t;
    smp_t         hist[$];
    int           m_dly = DEF;
    logic [W-1:0] m_dout = '0;
    logic         m_vld = 1'b0;
    logic         m_err = 1'b0;

    task automatic step(input logic r, input logic e, input logic [W-1:0] d,
                        input logic v, input logic ld, input logic [DW-1:0] nd);
        smp_t s;
        @(negedge clk);
        rst = r; bus.en = e; bus.din = d; bus.din_valid = v;
        bus.dly_load = ld; bus.dly = nd;
        @(posedge clk);
        m_err = 1'b0;
        if (r) begin
            hist.delete();
            m_dly = DEF; m_dout = '0; m_vld = 1'b0;
        end else if (ld) begin
            hist.delete();
            if (e) hist.push_back('{d, v});
            m_vld = 1'b0;
            if (int'(nd) > MAXD) begin
                m_dly = MAXD; m_err = 1'b1;
            end else begin
                m_dly = int'(nd);
            end
        end else if (e) begin
            hist.push_back('{d, v});
            if (hist.size() > m_dly) begin
                s = hist[hist.size() - 1 - m_dly];
                m_vld = s.v; m_dout = s.d;
            end else begin
                m_vld = 1'b0;
            end
        end
        while (hist.size() > MAXD + 1) void'(hist.pop_front());
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0);
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", bus.dout_valid); end
        total++; if (bus.dly_active !== DW'(DEF)) begin bad++; $display("FAIL reset_dly got=%0d exp=%0d", bus.dly_active, DEF); end
        total++; if (bus.dly_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.dly_err); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd0);
            total++; if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0) begin
                bad++; $display("FAIL idle_out cyc=%0d got=%h/%b exp=00/0", i, bus.dout, bus.dout_valid);
            end
            total++; if (bus.dly_active !== 5'd0 || bus.dly_err !== 1'b0) begin
                bad++; $display("FAIL idle_ctl cyc=%0d got=%0d/%b exp=0/0", i, bus.dly_active, bus.dly_err);
            end
        end
    endtask

    task automatic test_ramp_d0();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, W'(i), 1'b1, 1'b0, 5'd0);
            total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL d0_vld cyc=%0d got=%b exp=1", i, bus.dout_valid); end
            total++; if (bus.dout !== W'(i)) begin bad++; $display("FAIL d0_data cyc=%0d got=%h exp=%h", i, bus.dout, W'(i)); end
            total++; if (bus.dout_valid !== m_vld || (m_vld && bus.dout !== m_dout)) begin
                bad++; $display("FAIL d0_model cyc=%0d got=%h/%b exp=%h/%b", i, bus.dout, bus.dout_valid, m_dout, m_vld);
            end
        end
    endtask

    task automatic test_delay5();
        int first = -1;
        logic [W-1:0] fval = '0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd5);
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL d5_flush got=%b exp=0", bus.dout_valid); end
        total++; if (bus.dly_active !== 5'd5) begin bad++; $display("FAIL d5_dly got=%0d exp=5", bus.dly_active); end
        for (int n = 1; n <= 20; n++) begin
            step(1'b0, 1'b1, W'(8'h10 + n - 1), 1'b1, 1'b0, 5'd0);
            if (first < 0 && bus.dout_valid === 1'b1) begin first = n; fval = bus.dout; end
            total++; if (bus.dout_valid !== m_vld || (m_vld && bus.dout !== m_dout)) begin
                bad++; $display("FAIL d5_model n=%0d got=%h/%b exp=%h/%b", n, bus.dout, bus.dout_valid, m_dout, m_vld);
            end
        end
        total++; if (first != 6 || fval !== 8'h10) begin
            bad++; $display("FAIL d5_latency got=%0d/%h exp=6/10", first, fval);
        end
    endtask

    task automatic test_en_toggle();
        int first = -1, edges = 0, cnt = 0;
        logic e, v;
        logic [W-1:0] pd;
        logic pv;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd5);
        for (int i = 0; i < 60; i++) begin
            e = (i % 2 == 0);
            v = (cnt == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            pd = bus.dout; pv = bus.dout_valid;
            step(1'b0, e, W'(8'h30 + cnt), v, 1'b0, 5'd0);
            if (e) begin cnt++; edges++; end
            if (first < 0 && bus.dout_valid === 1'b1) first = edges;
            if (!e) begin
                total++; if (bus.dout !== pd || bus.dout_valid !== pv) begin
                    bad++; $display("FAIL tog_hold cyc=%0d got=%h/%b exp=%h/%b", i, bus.dout, bus.dout_valid, pd, pv);
                end
            end
            total++; if (bus.dout_valid !== m_vld || (m_vld && bus.dout !== m_dout)) begin
                bad++; $display("FAIL tog_model cyc=%0d got=%h/%b exp=%h/%b", i, bus.dout, bus.dout_valid, m_dout, m_vld);
            end
        end
        total++; if (first != 6) begin bad++; $display("FAIL tog_latency got=%0d exp=6", first); end
    endtask

    task automatic test_overrange();
        int first = -1, edges = 0;
        logic e;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd20);
        total++; if (bus.dly_active !== 5'd16) begin bad++; $display("FAIL ovr_dly got=%0d exp=16", bus.dly_active); end
        total++; if (bus.dly_err !== 1'b1) begin bad++; $display("FAIL ovr_err got=%b exp=1", bus.dly_err); end
        for (int i = 0; i < 80; i++) begin
            e = (edges == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(1'b0, e, (edges == 0) ? 8'h70 : W'($urandom), (edges == 0) ? 1'b1 : 1'(($urandom_range(0, 1))), 1'b0, 5'd0);
            if (e) edges++;
            if (first < 0 && bus.dout_valid === 1'b1) begin
                first = edges;
                total++; if (bus.dout !== 8'h70) begin bad++; $display("FAIL ovr_first got=%h exp=70", bus.dout); end
            end
            total++; if (bus.dly_err !== 1'b0 || bus.dly_err !== m_err) begin
                bad++; $display("FAIL ovr_errpulse cyc=%0d got=%b exp=0", i, bus.dly_err);
            end
            total++; if (bus.dout_valid !== m_vld || (m_vld && bus.dout !== m_dout)) begin
                bad++; $display("FAIL ovr_model cyc=%0d got=%h/%b exp=%h/%b", i, bus.dout, bus.dout_valid, m_dout, m_vld);
            end
        end
        total++; if (first != 17) begin bad++; $display("FAIL ovr_latency got=%0d exp=17", first); end
    endtask

    task automatic test_load_midstream();
        int first = -1;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd3);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, W'(8'h40 + i), 1'b1, 1'b0, 5'd0);
        total++; if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h48) begin
            bad++; $display("FAIL mid_pre got=%h/%b exp=48/1", bus.dout, bus.dout_valid);
        end
        step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 5'd1);
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL mid_flush got=%b exp=0", bus.dout_valid); end
        total++; if (bus.dly_active !== 5'd1) begin bad++; $display("FAIL mid_dly got=%0d exp=1", bus.dly_active); end
        for (int n = 1; n <= 10; n++) begin
            step(1'b0, 1'b1, W'(8'h60 + n), 1'b1, 1'b0, 5'd0);
            if (first < 0 && bus.dout_valid === 1'b1) begin
                first = n;
                total++; if (bus.dout !== 8'hAA) begin bad++; $display("FAIL mid_first got=%h exp=aa", bus.dout); end
            end
            total++; if (bus.dout_valid === 1'b1 && bus.dout >= 8'h40 && bus.dout <= 8'h4F) begin
                bad++; $display("FAIL mid_stale n=%0d got=%h exp=post-load sample", n, bus.dout);
            end
            total++; if (bus.dout_valid !== m_vld || (m_vld && bus.dout !== m_dout)) begin
                bad++; $display("FAIL mid_model n=%0d got=%h/%b exp=%h/%b", n, bus.dout, bus.dout_valid, m_dout, m_vld);
            end
        end
        total++; if (first != 1) begin bad++; $display("FAIL mid_latency got=%0d exp=1", first); end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd4);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, W'(8'h80 + i), 1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 5'd0);
        total++; if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_out got=%h/%b exp=00/0", bus.dout, bus.dout_valid);
        end
        total++; if (bus.dly_active !== DW'(DEF)) begin bad++; $display("FAIL rmid_dly got=%0d exp=%0d", bus.dly_active, DEF); end
        for (int n = 1; n <= 8; n++) begin
            step(1'b0, 1'b1, W'(8'hC0 + n - 1), 1'b1, 1'b0, 5'd0);
            if (first < 0 && bus.dout_valid === 1'b1) begin
                first = n;
                total++; if (bus.dout !== 8'hC0) begin bad++; $display("FAIL rmid_first got=%h exp=c0", bus.dout); end
            end
        end
        total++; if (first != DEF + 1) begin bad++; $display("FAIL rmid_latency got=%0d exp=%0d", first, DEF + 1); end
    endtask

    task automatic test_random();
        logic r, e, v, ld;
        logic [DW-1:0] nd;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 24) == 0);
            nd = DW'($urandom_range(0, 31));
            e  = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 4) != 0);
            step(r, e, W'($urandom), v, ld, nd);
            total++; if (bus.dout_valid !== m_vld || (m_vld && bus.dout !== m_dout)) begin
                bad++; $display("FAIL rnd_out cyc=%0d got=%h/%b exp=%h/%b", i, bus.dout, bus.dout_valid, m_dout, m_vld);
            end
            total++; if (bus.dly_active !== DW'(m_dly) || bus.dly_err !== m_err) begin
                bad++; $display("FAIL rnd_ctl cyc=%0d got=%0d/%b exp=%0d/%b", i, bus.dly_active, bus.dly_err, m_dly, m_err);
            end
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.din = '0; bus.din_valid = 1'b0;
        bus.dly_load = 1'b0; bus.dly = '0;
        test_reset();
        test_ramp_d0();
        test_delay5();
        test_en_toggle();
        test_overrange();
        test_load_midstream();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
